mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register and writeback mux of the RV32I core; sits directly upstream of the register file.
//  Captures memory-stage results, extracts and extends load data, selects the writeback value.
//  Drives the register-file write port (A3/WD3/WE3) and the hazard/forwarding unit.
//  Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
//  XLEN       32  datapath width; only 32 is supported
//  REG_AW     5   register address width
//  INSTRET_W  64  retire-counter width; used only when RETIRE_CNT_EN is defined
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  ValidM       in   1       MEM stage holds a real instruction
//  RegWriteM    in   1       instruction writes rd
//  ResultSrcM   in   2       00 = ALU, 01 = load, 10 = PC+4, 11 = ALU
//  Funct3M      in   3       load size/sign (RV32I funct3)
//  ALUResultM   in   XLEN    ALU result / load byte address
//  ReadDataM    in   XLEN    raw aligned 32-bit word from data memory
//  PCPlus4M     in   XLEN    PC+4 for JAL/JALR link
//  RdM          in   REG_AW  destination register
//  StallW       in   1       hold the W register contents
//  FlushW       in   1       insert a bubble into W
//  A3           out  REG_AW  register-file write address (= registered RdM)
//  WD3          out  XLEN    writeback data
//  WE3          out  1       register-file write enable
//  ValidW       out  1       W stage holds a real instruction
// BEHAVIOUR
//  - Reset: the clk and rst naming is already fixed. There is one clock, and reset is synchronous and active-high.
//    All W registers clear to 0, so ValidW = WE3 = 0, A3 = 0, WD3 = 0.
//  - Register update on posedge clk, in priority order:
//    - rst clears everything.
//    - Otherwise FlushW clears ValidW and RegWrite; data fields may keep their values.
//    - Otherwise StallW holds all fields.
//    - Otherwise all M fields are captured.
//  - When FlushW and StallW are both high, flush wins.
//  - Latency: 1 cycle from M inputs to A3/WD3/WE3. The outputs are combinational from W registers only; no path from M inputs.
//  - WE3 = ValidW & RegWriteW & (A3 != 0). x0 is never written, even when RegWriteM = 1.
//  - Load extraction uses the registered address offset off = ALUResultW[1:0]:
//    - LB  (000): byte at off, sign-extended
//    - LBU (100): byte at off, zero-extended
//    - LH  (001): halfword at off[1] (off[0] ignored), sign-extended
//    - LHU (101): halfword at off[1] (off[0] ignored), zero-extended
//    - LW  (010), and any other funct3: full word
//  - Byte order is little-endian: byte 0 = ReadData[7:0].
//  - WD3 mux:
//    - ResultSrcW = 01 selects the extracted load data.
//    - ResultSrcW = 10 selects PCPlus4W.
//    - 00 and 11 select ALUResultW.
//  - WD3 is driven by the mux regardless of WE3.
//  - Misalignment is not trapped here; the fixed extraction rules above apply.
// CONFIGURATION
//  - RETIRE_CNT_EN defined:
//    - Adds output InstretW [INSTRET_W-1:0], an instructions-retired counter.
//    - It increments by 1 on each clock edge where ValidW & ~StallW & ~rst.
//    - It counts every valid instruction, including ones with WE3 = 0.
//    - Reset value is 0. It wraps from all-ones to 0 without any flag.
//  - RETIRE_CNT_EN undefined: the counter and the InstretW port do not exist; all other behaviour is identical.
// TESTING
//  1. rst = 1 for 2 cycles with random M inputs -> ValidW = WE3 = 0, A3 = 0, WD3 = 0 (and InstretW = 0 if enabled).
//  2. ALU op: RdM = 5, ALUResultM = 0x0000_0028, ResultSrcM = 00, RegWriteM = 1 -> next cycle A3 = 5, WD3 = 0x28, WE3 = 1.
//  3. Loads with ReadDataM = 0x80FF_7F01:
//     - LB,  off 1 -> WD3 = 0x0000_007F
//     - LB,  off 2 -> WD3 = 0xFFFF_FFFF
//     - LBU, off 3 -> WD3 = 0x0000_0080
//     - LH,  off 2 -> WD3 = 0xFFFF_80FF
//     - LHU, off 0 -> WD3 = 0x0000_7F01
//     - LW          -> WD3 = 0x80FF_7F01
//  4. JAL with RdM = 1, PCPlus4M = 0x104, ResultSrcM = 10 -> WD3 = 0x104, WE3 = 1; the same op with RdM = 0 -> WE3 = 0.
//  5. Load instruction A in W, then StallW = 1 for 3 cycles while M changes -> A3/WD3/WE3 hold A's values.
//     Then FlushW = 1 together with StallW = 1 -> ValidW = WE3 = 0 next cycle.
//  6. With RETIRE_CNT_EN: 10 valid instructions, 2 bubbles, 3 stall cycles -> InstretW = 10.
//     Preload the counter near all-ones by forcing it, retire 2 -> InstretW wraps to 0 and then reads 1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, load extraction and writeback mux (RV32I)
// Optional instructions-retired counter (InstretW) enabled by defining RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int INSTRET_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [REG_AW-1:0] RdM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic [REG_AW-1:0] A3,
  output logic [XLEN-1:0]   WD3,
  output logic              WE3,
  output logic              ValidW
`ifdef RETIRE_CNT_EN
  ,
  output logic [INSTRET_W-1:0] InstretW
`endif
);

  logic              r_valid;
  logic              r_regwrite;
  logic [1:0]        r_rsrc;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_pc4;
  logic [REG_AW-1:0] r_rd;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load;

  // Flush only needs to kill the control bits; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rsrc     <= 2'b00;
      r_funct3   <= 3'b000;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_rd       <= '0;
    end else if (FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (!StallW) begin
      r_valid    <= ValidM;
      r_regwrite <= RegWriteM;
      r_rsrc     <= ResultSrcM;
      r_funct3   <= Funct3M;
      r_alu      <= ALUResultM;
      r_rdata    <= ReadDataM;
      r_pc4      <= PCPlus4M;
      r_rd       <= RdM;
    end
  end

  always_comb begin
    w_byte = r_rdata[7:0];
    case (r_alu[1:0])
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      2'd3:    w_byte = r_rdata[31:24];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    case (r_rsrc)
      2'b01:   WD3 = w_load;
      2'b10:   WD3 = r_pc4;
      default: WD3 = r_alu;
    endcase
  end

  assign A3     = r_rd;
  assign ValidW = r_valid;
  assign WE3    = r_valid & r_regwrite & (r_rd != '0);

`ifdef RETIRE_CNT_EN
  logic [INSTRET_W-1:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (r_valid && !StallW) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign InstretW = r_instret;
`endif

endmodule
